// File: rtl/fixlen_pkg.sv
// Shared definitions for the fixed-length packet transmitter and receiver.
// Both ends use these so they agree on symbol width and byte order
// (most-significant byte of a symbol travels first).
package fixlen_pkg;

  localparam int unsigned DEF_SYMBOL_PER_PACKET = 4;
  localparam int unsigned DEF_BYTES_PER_SYMBOL  = 4;
  localparam int unsigned DEF_BITS_PER_BYTES    = 8;
  localparam int unsigned SYMBOL_W = DEF_BYTES_PER_SYMBOL * DEF_BITS_PER_BYTES;

  // Width of one wide symbol for a given byte count and byte width.
  function automatic int unsigned symbol_width(input int unsigned bytes_per_symbol,
                                               input int unsigned bits_per_byte);
    return bytes_per_symbol * bits_per_byte;
  endfunction

  // Index width for a counter covering 0..n-1; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Result of checking one accepted symbol's sop/eop against its expected slot.
  typedef struct packed {
    logic sop_mismatch;
    logic eop_mismatch;
  } frame_chk_t;

endpackage

// File: rtl/fixlen_pos_counter.sv
// Wrap-around position counter, 0..Range-1.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (to zero)
//   clr_i  : load zero, has priority over inc_i
//   inc_i  : advance by one, wrapping from Range-1 to 0
//   cnt_o  : current position
//   last_o : position equals Range-1
module fixlen_pos_counter
  import fixlen_pkg::*;
#(
  parameter int unsigned Range = 4,
  parameter int unsigned Width = idx_width(Range)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [Width-1:0] LastVal = Width'(Range - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LastVal) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LastVal);

endmodule

// File: rtl/fix_length_p2b_tx.sv
// Fixed-length packet-to-bytes transmitter.
// Takes fixed-length packets of wide symbols on an Avalon-ST sink, holds one
// symbol at a time and streams it out MSB byte first on an Avalon-ST source,
// framing each packet with per-byte sop/eop. Input sop/eop are checked against
// the expected symbol slot; mismatches raise a one-cycle framing_error pulse.
// Ports:
//   clock_clk, reset_reset        : clock, synchronous active-high reset
//   asi_in0_*                     : symbol sink (data/valid/ready/sop/eop)
//   aso_out0_*                    : byte source (data/valid/ready/sop/eop)
//   framing_error                 : registered pulse, one per offending symbol
module fix_length_p2b_tx
  import fixlen_pkg::*;
#(
  parameter int unsigned SYMBOL_PER_PACKET = DEF_SYMBOL_PER_PACKET,
  parameter int unsigned BYTES_PER_SYMBOL  = DEF_BYTES_PER_SYMBOL,
  parameter int unsigned BITS_PER_BYTES    = DEF_BITS_PER_BYTES
) (
  input  logic                                       clock_clk,
  input  logic                                       reset_reset,
  input  logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] asi_in0_data,
  input  logic                                       asi_in0_valid,
  output logic                                       asi_in0_ready,
  input  logic                                       asi_in0_startofpacket,
  input  logic                                       asi_in0_endofpacket,
  output logic [BITS_PER_BYTES-1:0]                  aso_out0_data,
  output logic                                       aso_out0_valid,
  input  logic                                       aso_out0_ready,
  output logic                                       aso_out0_startofpacket,
  output logic                                       aso_out0_endofpacket,
  output logic                                       framing_error
);

  localparam int unsigned SymW    = symbol_width(BYTES_PER_SYMBOL, BITS_PER_BYTES);
  localparam int unsigned ByteW   = idx_width(BYTES_PER_SYMBOL);
  localparam int unsigned SymIdxW = idx_width(SYMBOL_PER_PACKET);

  localparam logic [SymIdxW-1:0] SymLastIdx = SymIdxW'(SYMBOL_PER_PACKET - 1);

  logic [SymW-1:0]    hold_q, hold_d;
  logic               full_q, full_d;
  logic               err_q, err_d;

  logic [ByteW-1:0]   byte_idx;
  logic               byte_at_last;
  logic [SymIdxW-1:0] sym_idx;
  logic               sym_at_last;

  logic               last_byte;
  logic               src_hs;
  logic               load;
  logic               sym_adv;
  logic [SymIdxW-1:0] exp_pos;
  logic               exp_first;
  logic               exp_last;
  frame_chk_t         frame_chk;
  logic [BITS_PER_BYTES-1:0] out_byte;

  assign last_byte = full_q && byte_at_last;
  assign src_hs    = full_q && aso_out0_ready;
  assign sym_adv   = src_hs && last_byte;

  // A new symbol may enter while the last byte of the held one leaves.
  assign asi_in0_ready = !full_q || (last_byte && aso_out0_ready);
  assign load          = asi_in0_valid && asi_in0_ready;

  // Expected slot of a symbol loaded this cycle: sym_idx after this cycle's advance.
  always_comb begin
    exp_pos = sym_idx;
    if (sym_adv) begin
      exp_pos = sym_at_last ? '0 : sym_idx + 1'b1;
    end
  end

  assign exp_first = (exp_pos == '0);
  assign exp_last  = (exp_pos == SymLastIdx);

  always_comb begin
    frame_chk.sop_mismatch = asi_in0_startofpacket != exp_first;
    frame_chk.eop_mismatch = asi_in0_endofpacket != exp_last;
    err_d = load && (|frame_chk);
  end

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (load) begin
      hold_d = asi_in0_data;
      full_d = 1'b1;
    end else if (sym_adv) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      hold_q <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

  fixlen_pos_counter #(
    .Range (BYTES_PER_SYMBOL)
  ) u_byte_cnt (
    .clk_i  (clock_clk),
    .rst_i  (reset_reset),
    .clr_i  (load),
    .inc_i  (src_hs && !byte_at_last),
    .cnt_o  (byte_idx),
    .last_o (byte_at_last)
  );

  // An input sop always realigns the packet position to slot 0.
  fixlen_pos_counter #(
    .Range (SYMBOL_PER_PACKET)
  ) u_sym_cnt (
    .clk_i  (clock_clk),
    .rst_i  (reset_reset),
    .clr_i  (load && asi_in0_startofpacket),
    .inc_i  (sym_adv),
    .cnt_o  (sym_idx),
    .last_o (sym_at_last)
  );

  // Byte 0 is the most-significant lane of the held symbol.
  always_comb begin
    out_byte = '0;
    for (int unsigned i = 0; i < BYTES_PER_SYMBOL; i++) begin
      if (byte_idx == ByteW'(i)) begin
        out_byte = hold_q[(BYTES_PER_SYMBOL - 1 - i) * BITS_PER_BYTES +: BITS_PER_BYTES];
      end
    end
  end

  assign aso_out0_valid         = full_q;
  assign aso_out0_data          = out_byte;
  assign aso_out0_startofpacket = full_q && (byte_idx == '0) && (sym_idx == '0);
  assign aso_out0_endofpacket   = last_byte && sym_at_last;
  assign framing_error          = err_q;

endmodule
